// File: rtl/veda_mem_port_arbiter.sv
// Shares one VEDA_MIPS memory port between instruction fetch (read-only) and load/store (read/write).
// Define VEDA_ARB_FAIR_EN to add the IF starvation guard; without it LS has strict priority.
module veda_mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_LATENCY = 1,
    parameter int MAX_STARVE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [DW-1:0] ls_rdata,
    output logic          mem_mode,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data_in,
    input  logic [DW-1:0] mem_data_out,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    // Handshake: a requester holds req and its payload until the one-cycle gnt pulse;
    // exactly one rvalid pulse follows each gnt, and only one transaction is ever in flight.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [2:0] LP_LAT_LAST = 3'(RD_LATENCY - 1);

    state_t        r_state;
    logic [2:0]    r_lat;
    logic          r_sel_ls;
    logic          r_we;
    logic          r_if_gnt;
    logic          r_if_rvalid;
    logic [DW-1:0] r_if_rdata;
    logic          r_ls_gnt;
    logic          r_ls_rvalid;
    logic [DW-1:0] r_ls_rdata;
    logic          r_mem_mode;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_data_in;
    logic          w_pick_if;

`ifdef VEDA_ARB_FAIR_EN
    localparam logic [3:0] LP_MAX_STARVE = 4'(MAX_STARVE);

    logic [3:0] r_starve;

    // IF is forced through once LS has been granted MAX_STARVE times in a row over a waiting IF.
    assign w_pick_if = if_req & (~ls_req | (r_starve == LP_MAX_STARVE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= 4'd0;
        end else if (r_state == S_IDLE) begin
            if (!if_req || w_pick_if) begin
                r_starve <= 4'd0;
            end else if (ls_req) begin
                r_starve <= r_starve + 4'd1;
            end
        end
    end
`else
    assign w_pick_if = if_req & ~ls_req;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_lat         <= 3'd0;
            r_sel_ls      <= 1'b0;
            r_we          <= 1'b0;
            r_if_gnt      <= 1'b0;
            r_if_rvalid   <= 1'b0;
            r_if_rdata    <= '0;
            r_ls_gnt      <= 1'b0;
            r_ls_rvalid   <= 1'b0;
            r_ls_rdata    <= '0;
            r_mem_mode    <= 1'b1;
            r_mem_addr    <= '0;
            r_mem_data_in <= '0;
        end else begin
            r_if_gnt    <= 1'b0;
            r_ls_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (if_req || ls_req) begin
                        r_state  <= S_ACCESS;
                        r_lat    <= 3'd0;
                        r_sel_ls <= ~w_pick_if;
                        if (w_pick_if) begin
                            r_mem_addr <= if_addr;
                            r_mem_mode <= 1'b1;
                            r_we       <= 1'b0;
                            r_if_gnt   <= 1'b1;
                        end else begin
                            r_mem_addr    <= ls_addr;
                            r_mem_data_in <= ls_wdata;
                            r_mem_mode    <= ~ls_we;
                            r_we          <= ls_we;
                            r_ls_gnt      <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    // The write strobe lasts only the first ACCESS cycle.
                    r_mem_mode <= 1'b1;
                    if (r_lat == LP_LAT_LAST) begin
                        r_state <= S_RESP;
                        if (r_sel_ls) begin
                            r_ls_rvalid <= 1'b1;
                            r_ls_rdata  <= r_we ? '0 : mem_data_out;
                        end else begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= mem_data_out;
                        end
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign if_gnt      = r_if_gnt;
    assign if_rvalid   = r_if_rvalid;
    assign if_rdata    = r_if_rdata;
    assign ls_gnt      = r_ls_gnt;
    assign ls_rvalid   = r_ls_rvalid;
    assign ls_rdata    = r_ls_rdata;
    assign mem_mode    = r_mem_mode;
    assign mem_addr    = r_mem_addr;
    assign mem_data_in = r_mem_data_in;
    assign busy        = (r_state != S_IDLE);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_veda_mem_port_arbiter.sv
// Self-checking bench for veda_mem_port_arbiter: vector table, directed corner sequences, random run vs model.
// Fairness expectations follow VEDA_ARB_FAIR_EN.
module tb_veda_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int RL_A = 1;
    localparam int RL_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic init_mem;

    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata, ls_rdata;
    logic          mem_mode, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in, mem_data_out;
    logic [1:0]    dbg_state;

    logic          b_if_req, b_if_gnt, b_if_rvalid;
    logic [AW-1:0] b_if_addr;
    logic [DW-1:0] b_if_rdata;
    logic          b_ls_req, b_ls_we, b_ls_gnt, b_ls_rvalid;
    logic [AW-1:0] b_ls_addr;
    logic [DW-1:0] b_ls_wdata, b_ls_rdata;
    logic          b_mem_mode, b_busy;
    logic [AW-1:0] b_mem_addr;
    logic [DW-1:0] b_mem_data_in, b_mem_data_out;
    logic [1:0]    b_dbg_state;

    veda_mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LATENCY(RL_A), .MAX_STARVE(4)) dut_a (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_mode(mem_mode), .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .busy(busy), .dbg_state(dbg_state)
    );

    veda_mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LATENCY(RL_B), .MAX_STARVE(4)) dut_b (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata),
        .ls_gnt(b_ls_gnt), .ls_rvalid(b_ls_rvalid), .ls_rdata(b_ls_rdata),
        .mem_mode(b_mem_mode), .mem_addr(b_mem_addr), .mem_data_in(b_mem_data_in), .mem_data_out(b_mem_data_out),
        .busy(b_busy), .dbg_state(b_dbg_state)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 5) ? 32'hDEADBEEF : (32'hA000_0000 + 32'(i));
    endfunction

    // Memories: A answers combinationally (latency 1), B through a 2-stage pipe (latency 3).
    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];
    logic [31:0] b_d1, b_d2;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 16; i++) begin
                mem_a[i] <= init_word(i);
                mem_b[i] <= init_word(i);
            end
        end else begin
            if (!mem_mode) mem_a[mem_addr[3:0]] <= mem_data_in;
            if (!b_mem_mode) mem_b[b_mem_addr[3:0]] <= b_mem_data_in;
        end
        b_d1 <= mem_b[b_mem_addr[3:0]];
        b_d2 <= b_d1;
    end

    assign mem_data_out   = mem_a[mem_addr[3:0]];
    assign b_mem_data_out = b_d2;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        ls_req;
        logic        ls_we;
        logic [3:0]  ls_addr;
        logic [31:0] ls_wdata;
        logic        if_req;
        logic [3:0]  if_addr;
        logic        exp_ls;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    // Reference model state for the random run.
    logic [31:0] ref_mem [16];
    int          m_left;
    int          m_starve;
    logic        m_is_ls;
    logic [31:0] m_data;
    logic        e_if_gnt, e_ls_gnt, e_if_rvalid, e_ls_rvalid;
    logic        pick_if;

    initial begin
        int ls_gnt_cyc, if_gnt_cyc, ls_rv_cnt, if_rv_cnt;
        int n_ls, n_ls_at_if, if_seen, rv_cnt, nxt;
        int rv_cyc [4];

        vecs[0] = '{1'b0, 1'b0, 4'd0, 32'h0,         1'b1, 4'd5, 1'b0, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b1, 4'd9, 32'h0000_1234, 1'b0, 4'd0, 1'b1, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 4'd0, 32'h0,         1'b1, 4'd9, 1'b0, 32'h0000_1234};
        vecs[3] = '{1'b1, 1'b0, 4'd2, 32'h0,         1'b1, 4'd7, 1'b1, 32'hA000_0002};
        vecs[4] = '{1'b1, 1'b1, 4'd3, 32'h0000_CAFE, 1'b1, 4'd3, 1'b1, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 4'd0, 32'h0,         1'b1, 4'd3, 1'b0, 32'h0000_CAFE};
        vecs[6] = '{1'b1, 1'b0, 4'd9, 32'h0,         1'b0, 4'd0, 1'b1, 32'h0000_1234};
        vecs[7] = '{1'b1, 1'b0, 4'd0, 32'h0,         1'b0, 4'd0, 1'b1, 32'hA000_0000};

        if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0;
        b_if_req = 0; b_if_addr = '0; b_ls_req = 0; b_ls_we = 0; b_ls_addr = '0; b_ls_wdata = '0;
        rst = 1'b0;
        init_mem = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        chk("rst mem_mode", mem_mode, 1);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_data_in", mem_data_in, 0);
        chk("rst if_gnt", if_gnt, 0);
        chk("rst ls_gnt", ls_gnt, 0);
        chk("rst if_rvalid", if_rvalid, 0);
        chk("rst ls_rvalid", ls_rvalid, 0);
        chk("rst if_rdata", if_rdata, 0);
        chk("rst ls_rdata", ls_rdata, 0);
        chk("rst busy", busy, 0);

        init_mem = 1'b0;
        rst = 1'b1;
        tick();

        // Table: one transaction per row; the losing request is dropped before its grant.
        for (int i = 0; i < 8; i++) begin
            ls_req = vecs[i].ls_req; ls_we = vecs[i].ls_we;
            ls_addr = AW'(vecs[i].ls_addr); ls_wdata = vecs[i].ls_wdata;
            if_req = vecs[i].if_req; if_addr = AW'(vecs[i].if_addr);
            tick();
            chk($sformatf("vec%0d ls_gnt", i), ls_gnt, vecs[i].exp_ls);
            chk($sformatf("vec%0d if_gnt", i), if_gnt, !vecs[i].exp_ls);
            chk($sformatf("vec%0d mem_mode_access", i), mem_mode, !(vecs[i].exp_ls && vecs[i].ls_we));
            chk($sformatf("vec%0d busy", i), busy, 1);
            ls_req = 0; if_req = 0;
            tick();
            chk($sformatf("vec%0d ls_rvalid", i), ls_rvalid, vecs[i].exp_ls);
            chk($sformatf("vec%0d if_rvalid", i), if_rvalid, !vecs[i].exp_ls);
            chk($sformatf("vec%0d rdata", i), vecs[i].exp_ls ? ls_rdata : if_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d mem_mode_resp", i), mem_mode, 1);
            tick();
            chk($sformatf("vec%0d idle", i), busy, 0);
        end

        // Simultaneous LS read and IF read: LS first, IF three cycles later.
        ls_req = 1; ls_we = 0; ls_addr = AW'(2); if_req = 1; if_addr = AW'(4);
        ls_gnt_cyc = -1; if_gnt_cyc = -1; ls_rv_cnt = 0; if_rv_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (ls_gnt) begin ls_gnt_cyc = c; ls_req = 0; end
            if (if_gnt) begin if_gnt_cyc = c; if_req = 0; end
            if (ls_rvalid) begin ls_rv_cnt++; chk("dual ls_rdata", ls_rdata, 32'hA000_0002); end
            if (if_rvalid) begin if_rv_cnt++; chk("dual if_rdata", if_rdata, 32'hA000_0004); end
        end
        ls_req = 0; if_req = 0;
        chk("dual ls_gnt_cycle", ls_gnt_cyc, 1);
        chk("dual if_gnt_cycle", if_gnt_cyc, 4);
        chk("dual ls_rvalid_count", ls_rv_cnt, 1);
        chk("dual if_rvalid_count", if_rv_cnt, 1);

        // LS held continuously against a waiting IF.
        ls_req = 1; ls_we = 0; ls_addr = AW'(0); if_req = 1; if_addr = AW'(1);
        n_ls = 0; n_ls_at_if = -1; if_seen = 0;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (ls_gnt) n_ls++;
            if (if_gnt && if_seen == 0) begin if_seen = 1; n_ls_at_if = n_ls; if_req = 0; end
        end
        ls_req = 0; if_req = 0;
        repeat (5) tick();
`ifdef VEDA_ARB_FAIR_EN
        chk("starve if_gnt_seen", if_seen, 1);
        chk("starve ls_gnts_before_if", n_ls_at_if, 4);
`else
        chk("starve if_gnt_seen", if_seen, 0);
        chk("starve ls_gnt_count", n_ls, 34);
`endif

        // Reset in the ACCESS cycle of a write.
        ls_req = 1; ls_we = 1; ls_addr = AW'(6); ls_wdata = 32'hBAD0_BAD0;
        tick();
        chk("rstw ls_gnt", ls_gnt, 1);
        chk("rstw mem_mode_low", mem_mode, 0);
        ls_req = 0; ls_we = 0;
        #2 rst = 1'b0;
        #1;
        chk("rstw mem_mode_async", mem_mode, 1);
        chk("rstw busy_async", busy, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        ls_rv_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ls_rvalid) ls_rv_cnt++;
        end
        chk("rstw no_ls_rvalid", ls_rv_cnt, 0);
        chk("rstw mem_unwritten", mem_a[6], init_word(6));
        if_req = 1; if_addr = AW'(6);
        tick();
        chk("rstw if_gnt", if_gnt, 1);
        if_req = 0;
        tick();
        chk("rstw if_rvalid", if_rvalid, 1);
        chk("rstw if_rdata", if_rdata, init_word(6));
        tick();

        // RD_LATENCY=3: back-to-back IF reads of addresses 0..3.
        b_if_req = 1; b_if_addr = AW'(0); nxt = 0; rv_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (b_if_gnt) begin
                nxt++;
                if (nxt < 4) b_if_addr = AW'(nxt);
                else b_if_req = 0;
            end
            if (b_if_rvalid) begin
                if (rv_cnt < 4) begin
                    rv_cyc[rv_cnt] = c;
                    chk($sformatf("lat3 rdata%0d", rv_cnt), b_if_rdata, init_word(rv_cnt));
                end
                rv_cnt++;
            end
        end
        b_if_req = 0;
        chk("lat3 rvalid_count", rv_cnt, 4);
        if (rv_cnt >= 4) begin
            chk("lat3 first_rvalid_cycle", rv_cyc[0], 4);
            for (int j = 1; j < 4; j++) chk($sformatf("lat3 interval%0d", j), rv_cyc[j] - rv_cyc[j-1], 5);
        end

        // Random traffic against the transaction-level model.
        init_mem = 1'b1;
        tick();
        init_mem = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        m_left = 0; m_starve = 0; m_is_ls = 0; m_data = '0;
        for (int c = 0; c < 600; c++) begin
            tick();
            e_if_gnt = 0; e_ls_gnt = 0; e_if_rvalid = 0; e_ls_rvalid = 0;
            if (m_left == 0) begin
                if (ls_req || if_req) begin
`ifdef VEDA_ARB_FAIR_EN
                    pick_if = if_req && (!ls_req || m_starve == 4);
                    if (!if_req || pick_if) m_starve = 0;
                    else m_starve++;
`else
                    pick_if = if_req && !ls_req;
`endif
                    if (pick_if) begin
                        e_if_gnt = 1; m_is_ls = 0; m_data = ref_mem[if_addr[3:0]];
                    end else begin
                        e_ls_gnt = 1; m_is_ls = 1;
                        if (ls_we) begin ref_mem[ls_addr[3:0]] = ls_wdata; m_data = '0; end
                        else m_data = ref_mem[ls_addr[3:0]];
                    end
                    m_left = RL_A + 1;
                end else begin
                    m_starve = 0;
                end
            end else begin
                m_left--;
                if (m_left == 1) begin
                    if (m_is_ls) e_ls_rvalid = 1;
                    else e_if_rvalid = 1;
                end
            end
            chk($sformatf("rnd%0d if_gnt", c), if_gnt, e_if_gnt);
            chk($sformatf("rnd%0d ls_gnt", c), ls_gnt, e_ls_gnt);
            chk($sformatf("rnd%0d if_rvalid", c), if_rvalid, e_if_rvalid);
            chk($sformatf("rnd%0d ls_rvalid", c), ls_rvalid, e_ls_rvalid);
            if (e_if_rvalid) chk($sformatf("rnd%0d if_rdata", c), if_rdata, m_data);
            if (e_ls_rvalid) chk($sformatf("rnd%0d ls_rdata", c), ls_rdata, m_data);

            if (!ls_req || e_ls_gnt) begin
                ls_req = ($urandom_range(0, 2) != 0);
                ls_we = $urandom_range(0, 1) == 1;
                ls_addr = AW'($urandom_range(0, 15));
                ls_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                ls_req = 0;
            end
            if (!if_req || e_if_gnt) begin
                if_req = ($urandom_range(0, 2) != 0);
                if_addr = AW'($urandom_range(0, 15));
            end else if ($urandom_range(0, 15) == 0) begin
                if_req = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
